// File: rtl/pipe_hazard_sb_pkg.sv
// rtl/pipe_hazard_sb_pkg.sv - shared constants for the ID-stage hazard scoreboard
package pipe_hazard_sb_pkg;

    localparam int SB_RN_W       = 5;
    localparam int SB_FWD_STAGES = 3;
    localparam int FWD_RF        = 0;

    // Queue entry layout is {we, num[RN_W-1:0], load}; an all-zero entry is a bubble.
    localparam logic [SB_RN_W+1:0] SB_BUBBLE = '0;

    function automatic int fs_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_sb_entry_q.sv
// rtl/pipe_sb_entry_q.sv - shift queue of in-flight destination entries (EXE..WB)
module pipe_sb_entry_q #(
    parameter int             W      = 7,
    parameter int             DEPTH  = 3,
    parameter logic [W-1:0]   BUBBLE = '0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [W-1:0]              din,
    output logic [DEPTH-1:0][W-1:0]   q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= {DEPTH{BUBBLE}};
        end else begin
            q[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                q[k] <= q[k-1];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_sb.sv
// rtl/pipe_hazard_sb.sv - forwarding selects, load-use and mul/div interlocks, stall counter
module pipe_hazard_sb
    import pipe_hazard_sb_pkg::*;
#(
    parameter int RN_W       = SB_RN_W,
    parameter int FWD_STAGES = SB_FWD_STAGES,
    parameter int LOAD_READY = 1,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 16,
    localparam int FS_W      = fs_width(FWD_STAGES)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              id_valid,
    input  logic [RN_W-1:0]   id_rs,
    input  logic [RN_W-1:0]   id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_we,
    input  logic [RN_W-1:0]   id_reg_w_num,
    input  logic              id_is_load,
    input  logic              id_md_start,
    input  logic [RN_W-1:0]   id_md_dst,
    input  logic              flush,
    output logic [FS_W-1:0]   fwda,
    output logic [FS_W-1:0]   fwdb,
    output logic              nostall,
    output logic              md_busy,
    output logic              md_wb_valid,
    output logic [RN_W-1:0]   md_wb_num,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int EW   = RN_W + 2;
    localparam int MC_W = $clog2(MD_LAT);
    localparam logic [EW-1:0] BUBBLE = EW'(SB_BUBBLE);

    logic [FWD_STAGES-1:0][EW-1:0] ent;
    logic [EW-1:0]   ent_in;
    logic            rs_early_load, rt_early_load;
    logic            load_use, md_stall, accept;
    logic [MC_W-1:0] md_cnt;
    logic [RN_W-1:0] md_dst;

    pipe_sb_entry_q #(.W(EW), .DEPTH(FWD_STAGES), .BUBBLE(BUBBLE)) u_entry_q (
        .clk (clk),
        .clr (clr),
        .din (ent_in),
        .q   (ent)
    );

    // Scan oldest to youngest so the youngest match is the last one assigned.
    always_comb begin
        fwda          = FS_W'(FWD_RF);
        fwdb          = FS_W'(FWD_RF);
        rs_early_load = 1'b0;
        rt_early_load = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (ent[k][EW-1] && ent[k][RN_W:1] == id_rs && id_rs != '0) begin
                fwda          = FS_W'(k + 1);
                rs_early_load = ent[k][0] && (k < LOAD_READY);
            end
            if (ent[k][EW-1] && ent[k][RN_W:1] == id_rt && id_rt != '0) begin
                fwdb          = FS_W'(k + 1);
                rt_early_load = ent[k][0] && (k < LOAD_READY);
            end
        end
    end

    always_comb begin
        load_use = (id_use_rs & rs_early_load) | (id_use_rt & rt_early_load);
        md_stall = md_busy & (id_md_start |
                   ((md_dst != '0) & ((id_use_rs & (id_rs == md_dst)) |
                                      (id_use_rt & (id_rt == md_dst)) |
                                      (id_reg_we & (id_reg_w_num == md_dst)))));
        nostall  = ~(id_valid & ~flush & (load_use | md_stall));
        accept   = id_valid & nostall & ~flush;
        ent_in   = accept ? {id_reg_we, id_reg_w_num, id_is_load} : BUBBLE;
    end

    // The write-back pulse fires on the edge where the countdown leaves 1.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            md_cnt      <= '0;
            md_dst      <= '0;
            md_busy     <= 1'b0;
            md_wb_valid <= 1'b0;
            md_wb_num   <= '0;
        end else begin
            md_wb_valid <= 1'b0;
            if (accept && id_md_start) begin
                md_cnt  <= MC_W'(MD_LAT - 1);
                md_dst  <= id_md_dst;
                md_busy <= 1'b1;
            end else if (md_busy) begin
                md_cnt <= md_cnt - 1'b1;
                if (md_cnt == MC_W'(1)) begin
                    md_busy     <= 1'b0;
                    md_wb_valid <= 1'b1;
                    md_wb_num   <= md_dst;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt <= '0;
        end else if (!nostall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// tb/tb_pipe_hazard_sb.sv - scoreboard bench for pipe_hazard_sb with a history-based model
module tb_pipe_hazard_sb;

    localparam int RN_W = 5;
    localparam int FS   = 3;
    localparam int LR   = 1;
    localparam int ML   = 4;
    localparam int CW   = 16;
    localparam int FS_W = 2;
    localparam int HMAX = 8192;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic            id_valid, id_use_rs, id_use_rt, id_reg_we, id_is_load, id_md_start, flush;
    logic [RN_W-1:0] id_rs, id_rt, id_reg_w_num, id_md_dst;
    logic [FS_W-1:0] fwda, fwdb;
    logic            nostall, md_busy, md_wb_valid;
    logic [RN_W-1:0] md_wb_num;
    logic [CW-1:0]   stall_cnt;

    pipe_hazard_sb #(.RN_W(RN_W), .FWD_STAGES(FS), .LOAD_READY(LR), .MD_LAT(ML), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_we(id_reg_we),
        .id_reg_w_num(id_reg_w_num), .id_is_load(id_is_load), .id_md_start(id_md_start),
        .id_md_dst(id_md_dst), .flush(flush), .fwda(fwda), .fwdb(fwdb), .nostall(nostall),
        .md_busy(md_busy), .md_wb_valid(md_wb_valid), .md_wb_num(md_wb_num), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid, use_rs, use_rt, we, load, md_start, flush;
        bit [4:0] rs, rt, wn, md_dst;
    } stim_t;

    typedef struct {
        int fwda, fwdb, nostall, md_busy, md_wb_valid, md_wb_num, stall_cnt, cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: h_we/h_num/h_load[c] = what ID handed to the pipe in cycle c (0 for a bubble).
    bit h_we[HMAX];
    bit h_load[HMAX];
    int h_num[HMAX];
    int t, md_done, md_dst_p, last_wb, m_stall;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (model cycle %0d)", nm, act, exp_v, t);
        end
    endtask

    function automatic void model_reset();
        t        = 0;
        md_done  = -1;
        md_dst_p = 0;
        last_wb  = 0;
        m_stall  = 0;
    endfunction

    function automatic void find_src(input int r, output int sel, output bit early_ld);
        sel      = 0;
        early_ld = 1'b0;
        for (int k = 0; k < FS; k++) begin
            int c = t - 1 - k;
            if (c >= 0 && r != 0 && h_we[c] && h_num[c] == r) begin
                sel      = k + 1;
                early_ld = h_load[c] && (k < LR);
                return;
            end
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t wr(input int n, input bit ld);
        stim_t s = idle();
        s.valid = 1; s.we = 1; s.wn = 5'(n); s.load = ld;
        return s;
    endfunction

    function automatic stim_t rd(input int rs, input int rt, input bit urs, input bit urt);
        stim_t s = idle();
        s.valid = 1; s.rs = 5'(rs); s.rt = 5'(rt); s.use_rs = urs; s.use_rt = urt;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.valid; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs;
        id_use_rt = s.use_rt; id_reg_we = s.we; id_reg_w_num = s.wn; id_is_load = s.load;
        id_md_start = s.md_start; id_md_dst = s.md_dst; flush = s.flush;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit   lda, ldb, busy, lu, mds, ns, acc;
        @(posedge clk);
        #1;
        apply(s);
        find_src(s.rs, e.fwda, lda);
        find_src(s.rt, e.fwdb, ldb);
        busy = (t < md_done);
        if (t == md_done) last_wb = md_dst_p;
        e.md_wb_valid = (t == md_done);
        e.md_wb_num   = last_wb;
        e.md_busy     = busy;
        e.stall_cnt   = m_stall;
        lu  = (s.use_rs && lda) || (s.use_rt && ldb);
        mds = busy && (s.md_start || (md_dst_p != 0 &&
              ((s.use_rs && s.rs == md_dst_p) || (s.use_rt && s.rt == md_dst_p) ||
               (s.we && s.wn == md_dst_p))));
        ns  = !(s.valid && !s.flush && (lu || mds));
        e.nostall = ns;
        e.cyc     = t;
        if (!ns && m_stall < 65535) m_stall++;
        acc       = s.valid && ns && !s.flush;
        h_we[t]   = acc && s.we;
        h_num[t]  = s.wn;
        h_load[t] = acc && s.load;
        if (acc && s.md_start) begin
            md_done  = t + ML;
            md_dst_p = s.md_dst;
        end
        exp_q.push_back(e);
        t++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("fwda",        int'(fwda),        e.fwda);
            chk("fwdb",        int'(fwdb),        e.fwdb);
            chk("nostall",     int'(nostall),     e.nostall);
            chk("md_busy",     int'(md_busy),     e.md_busy);
            chk("md_wb_valid", int'(md_wb_valid), e.md_wb_valid);
            chk("md_wb_num",   int'(md_wb_num),   e.md_wb_num);
            chk("stall_cnt",   int'(stall_cnt),   e.stall_cnt);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fwda"},        int'(fwda),        0);
        chk({tag, "_fwdb"},        int'(fwdb),        0);
        chk({tag, "_nostall"},     int'(nostall),     1);
        chk({tag, "_md_busy"},     int'(md_busy),     0);
        chk({tag, "_md_wb_valid"}, int'(md_wb_valid), 0);
        chk({tag, "_md_wb_num"},   int'(md_wb_num),   0);
        chk({tag, "_stall_cnt"},   int'(stall_cnt),   0);
    endtask

    // Reset lands mid-cycle while the queue holds r3 and an MD op is pending.
    task automatic mid_reset();
        @(posedge clk);
        #1;
        apply(rd(3, 9, 1, 1));
        #1;
        chk("pre_reset_md_busy", int'(md_busy), 1);
        clr = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk);
        #1;
        clr = 1'b0;
        apply(idle());
        model_reset();
    endtask

    initial begin
        stim_t s;
        model_reset();
        apply(idle());
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        clr = 1'b0;

        step(wr(3, 0));
        step(rd(3, 0, 1, 0));
        step(rd(3, 0, 0, 0));

        step(wr(5, 1));
        step(rd(0, 5, 0, 1));
        step(rd(0, 5, 0, 1));

        step(wr(7, 0));
        step(wr(7, 0));
        step(rd(7, 0, 1, 0));
        step(wr(0, 0));
        step(rd(0, 0, 1, 1));

        s = idle(); s.valid = 1; s.md_start = 1; s.md_dst = 9;
        step(s);
        repeat (5) step(rd(9, 0, 1, 0));

        step(wr(5, 1));
        s = rd(0, 5, 0, 1); s.flush = 1;
        step(s);
        step(rd(0, 5, 0, 1));

        step(wr(3, 0));
        s = idle(); s.valid = 1; s.md_start = 1; s.md_dst = 9;
        step(s);
        step(idle());
        mid_reset();

        for (int i = 0; i < 3000; i++) begin
            s          = idle();
            s.valid    = ($urandom_range(0, 9) != 0);
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.use_rs   = $urandom_range(0, 1);
            s.use_rt   = $urandom_range(0, 1);
            s.we       = ($urandom_range(0, 3) != 0);
            s.wn       = 5'($urandom_range(0, 3));
            s.load     = ($urandom_range(0, 2) == 0);
            s.md_start = ($urandom_range(0, 11) == 0);
            s.md_dst   = 5'($urandom_range(0, 3));
            s.flush    = ($urandom_range(0, 9) == 0);
            step(s);
        end
        step(idle());

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
